// File: rtl/vend_ctrl_if.sv
// ---------------------------------------------------------------------------
// vend_ctrl_if
//   Groups the coin/button front-end inputs and the actuator/display outputs
//   of the vending controller into one bundle.
//
//   Front end -> controller : coin_100, coin_500, sel_valid, sel[1:0], cancel
//   Controller -> actuators : credit[5:0], vend, vend_item[1:0], deny,
//                             coin_reject, change_100, change_500, busy
//
//   master : the side that produces coin/button pulses (front end, bench)
//   slave  : the controller itself
// ---------------------------------------------------------------------------
interface vend_ctrl_if;
    logic       coin_100;
    logic       coin_500;
    logic       sel_valid;
    logic [1:0] sel;
    logic       cancel;

    logic [5:0] credit;
    logic       vend;
    logic [1:0] vend_item;
    logic       deny;
    logic       coin_reject;
    logic       change_100;
    logic       change_500;
    logic       busy;

    modport master (
        output coin_100, coin_500, sel_valid, sel, cancel,
        input  credit, vend, vend_item, deny, coin_reject,
               change_100, change_500, busy
    );

    modport slave (
        input  coin_100, coin_500, sel_valid, sel, cancel,
        output credit, vend, vend_item, deny, coin_reject,
               change_100, change_500, busy
    );
endinterface

// File: rtl/vend_ctrl.sv
// ---------------------------------------------------------------------------
// vend_ctrl
//   Vending-machine sequencing controller. Accepts 100/500-won coin pulses,
//   keeps the credit (in 100-won units), vends when the credit covers the
//   selected price, pays change back one coin per cycle (500s first), and
//   refunds on cancel or after TIMEOUT_S idle seconds in the CREDIT state.
//
//   Ports
//     i_clk  : system clock, everything on the rising edge
//     reset  : synchronous, active-low reset
//     bus    : vend_ctrl_if.slave (coins/buttons in, actuator pulses out)
//
//   All outputs are registered; credit is the credit register itself.
// ---------------------------------------------------------------------------
module vend_ctrl #(
    parameter int CLK_HZ     = 100,
    parameter int TIMEOUT_S  = 10,
    parameter int PRICE0     = 3,
    parameter int PRICE1     = 5,
    parameter int PRICE2     = 7,
    parameter int PRICE3     = 12,
    parameter int MAX_CREDIT = 30
) (
    input  logic        i_clk,
    input  logic        reset,
    vend_ctrl_if.slave  bus
);

    localparam int PW = $clog2(CLK_HZ);
    localparam int SW = $clog2(TIMEOUT_S + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
    localparam logic [SW-1:0] SEC_LAST   = SW'(TIMEOUT_S - 1);
    localparam logic [6:0]    CREDIT_MAX = 7'(MAX_CREDIT);

    localparam int PRICES [4] = '{PRICE0, PRICE1, PRICE2, PRICE3};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CREDIT = 2'd1,
        S_VEND   = 2'd2,
        S_CHANGE = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Price table
    // ------------------------------------------------------------------
    logic [5:0] price_tbl [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_price
            assign price_tbl[gi] = 6'(PRICES[gi]);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t        state_q,       state_d;
    logic [5:0]    credit_q,      credit_d;
    logic [1:0]    item_q,        item_d;
    logic [PW-1:0] presc_q,       presc_d;
    logic [SW-1:0] sec_q,         sec_d;
    logic          vend_q,        vend_d;
    logic [1:0]    vend_item_q,   vend_item_d;
    logic          deny_q,        deny_d;
    logic          coin_reject_q, coin_reject_d;
    logic          change_100_q,  change_100_d;
    logic          change_500_q,  change_500_d;
    logic          busy_q,        busy_d;

    // ------------------------------------------------------------------
    // Coin decode: 500 wins when both pulses arrive together, and the
    // 100 coin of that pair is always handed back.
    // ------------------------------------------------------------------
    logic       coin_any;
    logic       coin_dup;
    logic [2:0] coin_val;
    logic [6:0] credit_sum;
    logic       coin_fits;
    logic       timeout_hit;
    logic [5:0] sel_price;
    logic [5:0] credit_after_vend;

    always_comb begin
        coin_any          = bus.coin_100 | bus.coin_500;
        coin_dup          = bus.coin_100 & bus.coin_500;
        coin_val          = bus.coin_500 ? 3'd5 : (bus.coin_100 ? 3'd1 : 3'd0);
        credit_sum        = {1'b0, credit_q} + 7'(coin_val);
        coin_fits         = (credit_sum <= CREDIT_MAX);
        sel_price         = price_tbl[bus.sel];
        credit_after_vend = credit_q - price_tbl[item_q];
        // Fires on the cycle the seconds counter would reach TIMEOUT_S,
        // so CHANGE is entered exactly TIMEOUT_S*CLK_HZ edges after a clear.
        timeout_hit       = (presc_q == PRESC_LAST) && (sec_q == SEC_LAST);
    end

    // ------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        item_d        = item_q;
        presc_d       = '0;        // counters idle at zero unless advanced
        sec_d         = '0;
        vend_d        = 1'b0;
        vend_item_d   = '0;
        deny_d        = 1'b0;
        coin_reject_d = 1'b0;
        change_100_d  = 1'b0;
        change_500_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (coin_any) begin
                    if (coin_fits) begin
                        credit_d      = credit_sum[5:0];
                        state_d       = S_CREDIT;
                        coin_reject_d = coin_dup;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
                deny_d = bus.sel_valid;
            end

            S_CREDIT: begin
                if (bus.cancel) begin
                    // Cancel pre-empts everything else this cycle.
                    state_d       = S_CHANGE;
                    coin_reject_d = coin_any;
                end else if (bus.sel_valid) begin
                    coin_reject_d = coin_any;
                    if (credit_q >= sel_price) begin
                        state_d = S_VEND;
                        item_d  = bus.sel;
                    end else begin
                        // Denied select counts as activity: counters stay cleared.
                        deny_d = 1'b1;
                    end
                end else if (coin_any && coin_fits) begin
                    credit_d      = credit_sum[5:0];
                    coin_reject_d = coin_dup;
                end else begin
                    // No activity (an overflowing coin is not activity).
                    coin_reject_d = coin_any;
                    if (timeout_hit) begin
                        state_d = S_CHANGE;
                    end else if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        sec_d   = sec_q + SW'(1);
                    end else begin
                        presc_d = presc_q + PW'(1);
                        sec_d   = sec_q;
                    end
                end
            end

            S_VEND: begin
                vend_d        = 1'b1;
                vend_item_d   = item_q;
                credit_d      = credit_after_vend;
                state_d       = (credit_after_vend != 6'd0) ? S_CHANGE : S_IDLE;
                coin_reject_d = coin_any;
                deny_d        = bus.sel_valid;
            end

            S_CHANGE: begin
                if (credit_q >= 6'd5) begin
                    change_500_d = 1'b1;
                    credit_d     = credit_q - 6'd5;
                end else if (credit_q != 6'd0) begin
                    change_100_d = 1'b1;
                    credit_d     = credit_q - 6'd1;
                end else begin
                    state_d = S_IDLE;
                end
                coin_reject_d = coin_any;
                deny_d        = bus.sel_valid;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_VEND) || (state_d == S_CHANGE);
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            credit_q      <= '0;
            item_q        <= '0;
            presc_q       <= '0;
            sec_q         <= '0;
            vend_q        <= 1'b0;
            vend_item_q   <= '0;
            deny_q        <= 1'b0;
            coin_reject_q <= 1'b0;
            change_100_q  <= 1'b0;
            change_500_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            item_q        <= item_d;
            presc_q       <= presc_d;
            sec_q         <= sec_d;
            vend_q        <= vend_d;
            vend_item_q   <= vend_item_d;
            deny_q        <= deny_d;
            coin_reject_q <= coin_reject_d;
            change_100_q  <= change_100_d;
            change_500_q  <= change_500_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.credit      = credit_q;
    assign bus.vend        = vend_q;
    assign bus.vend_item   = vend_item_q;
    assign bus.deny        = deny_q;
    assign bus.coin_reject = coin_reject_q;
    assign bus.change_100  = change_100_q;
    assign bus.change_500  = change_500_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vend_ctrl
//   Stimulus drives one input set per cycle and pushes the expected output
//   set (from a transaction-level vending model) into a queue; a monitor
//   pops one entry per clock and compares it with what the controller shows.
// ---------------------------------------------------------------------------
module tb_vend_ctrl;

    localparam int HZ   = 4;
    localparam int TS   = 2;
    localparam int MAXC = 30;

    int PR [4] = '{3, 5, 7, 12};

    logic i_clk = 1'b0;
    logic reset = 1'b0;

    always #5 i_clk = ~i_clk;

    vend_ctrl_if bus ();

    vend_ctrl #(
        .CLK_HZ     (HZ),
        .TIMEOUT_S  (TS),
        .PRICE0     (3),
        .PRICE1     (5),
        .PRICE2     (7),
        .PRICE3     (12),
        .MAX_CREDIT (MAXC)
    ) dut (
        .i_clk (i_clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [5:0] credit;
        logic       vend;
        logic [1:0] item;
        logic       deny;
        logic       rej;
        logic       c100;
        logic       c500;
        logic       busy;
    } obs_t;

    obs_t exp_q [$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // ------------------------------------------------------------------
    // Reference model: a session holds credit; a refund is a precomputed
    // list of coins paid one per cycle; timeout is a count of quiet cycles.
    // ------------------------------------------------------------------
    localparam int P_IDLE = 0, P_CREDIT = 1, P_VEND = 2, P_REFUND = 3;

    int m_phase = P_IDLE;
    int m_credit = 0;
    int m_item = 0;
    int m_quiet = 0;
    int m_coins [$];

    function automatic void start_refund();
        m_phase = P_REFUND;
        m_coins.delete();
        for (int i = 0; i < m_credit / 5; i++) m_coins.push_back(5);
        for (int i = 0; i < m_credit % 5; i++) m_coins.push_back(1);
    endfunction

    function automatic obs_t model_step(bit rst_n, bit c1, bit c5, bit sv,
                                        int s, bit cn);
        obs_t e;
        int   v;
        bit   fit;
        e = '0;
        if (!rst_n) begin
            m_phase  = P_IDLE;
            m_credit = 0;
            m_quiet  = 0;
            m_coins.delete();
        end else begin
            v   = c5 ? 5 : (c1 ? 1 : 0);
            fit = (v > 0) && (m_credit + v <= MAXC);
            case (m_phase)
                P_IDLE: begin
                    if (fit) begin
                        m_credit += v;
                        m_phase   = P_CREDIT;
                        m_quiet   = 0;
                        e.rej     = c1 && c5;
                    end else if (v > 0) begin
                        e.rej = 1'b1;
                    end
                    e.deny = sv;
                end
                P_CREDIT: begin
                    if (cn) begin
                        start_refund();
                        e.rej = (v > 0);
                    end else if (sv) begin
                        e.rej = (v > 0);
                        if (m_credit >= PR[s]) begin
                            m_item  = s;
                            m_phase = P_VEND;
                        end else begin
                            e.deny  = 1'b1;
                            m_quiet = 0;
                        end
                    end else if (fit) begin
                        m_credit += v;
                        m_quiet   = 0;
                        e.rej     = c1 && c5;
                    end else begin
                        e.rej = (v > 0);
                        m_quiet++;
                        if (m_quiet == TS * HZ) start_refund();
                    end
                end
                P_VEND: begin
                    e.vend    = 1'b1;
                    e.item    = 2'(m_item);
                    m_credit -= PR[m_item];
                    if (m_credit > 0) start_refund();
                    else m_phase = P_IDLE;
                    e.rej  = (v > 0);
                    e.deny = sv;
                end
                default: begin
                    if (m_coins.size() == 0) begin
                        m_phase = P_IDLE;
                    end else begin
                        v = m_coins.pop_front();
                        if (v == 5) e.c500 = 1'b1;
                        else        e.c100 = 1'b1;
                        m_credit -= v;
                    end
                    e.rej  = c1 || c5;
                    e.deny = sv;
                end
            endcase
        end
        e.credit = 6'(m_credit);
        e.busy   = (m_phase == P_VEND) || (m_phase == P_REFUND);
        return e;
    endfunction

    // ------------------------------------------------------------------
    // Stimulus helpers: exactly one call per clock cycle.
    // ------------------------------------------------------------------
    task automatic step(input bit c1, input bit c5, input bit sv,
                        input int s, input bit cn, input bit rst_n);
        @(negedge i_clk);
        bus.coin_100  = c1;
        bus.coin_500  = c5;
        bus.sel_valid = sv;
        bus.sel       = 2'(s);
        bus.cancel    = cn;
        reset         = rst_n;
        exp_q.push_back(model_step(rst_n, c1, c5, sv, s, cn));
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 1);
    endtask

    task automatic c100();
        step(1, 0, 0, 0, 0, 1);
    endtask

    task automatic c500();
        step(0, 1, 0, 0, 0, 1);
    endtask

    task automatic pick(input int s);
        step(0, 0, 1, s, 0, 1);
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    obs_t mon_e;
    obs_t mon_a;

    always @(posedge i_clk) begin
        cyc++;
        #1;
        if (exp_q.size() > 0) begin
            mon_e        = exp_q.pop_front();
            mon_a.credit = bus.credit;
            mon_a.vend   = bus.vend;
            mon_a.item   = mon_e.vend ? bus.vend_item : 2'b00;
            mon_a.deny   = bus.deny;
            mon_a.rej    = bus.coin_reject;
            mon_a.c100   = bus.change_100;
            mon_a.c500   = bus.change_500;
            mon_a.busy   = bus.busy;
            total++;
            if (mon_a !== mon_e) begin
                bad++;
                $display("FAIL outputs cyc=%0d got credit=%0d vend=%b item=%0d deny=%b rej=%b c100=%b c500=%b busy=%b want credit=%0d vend=%b item=%0d deny=%b rej=%b c100=%b c500=%b busy=%b",
                         cyc, mon_a.credit, mon_a.vend, mon_a.item, mon_a.deny,
                         mon_a.rej, mon_a.c100, mon_a.c500, mon_a.busy,
                         mon_e.credit, mon_e.vend, mon_e.item, mon_e.deny,
                         mon_e.rej, mon_e.c100, mon_e.c500, mon_e.busy);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached got running want finished");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        bus.coin_100  = 1'b0;
        bus.coin_500  = 1'b0;
        bus.sel_valid = 1'b0;
        bus.sel       = 2'b00;
        bus.cancel    = 1'b0;

        // Reset state
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
        quiet(2);

        // Exact credit: 7, item 2 -> vend, no change
        c500(); c100(); c100(); pick(2); quiet(4);

        // Credit 11, item 0 -> vend, change 500 + 3x100
        c500(); c500(); c100(); pick(0); quiet(8);

        // Credit ceiling
        for (int i = 0; i < 5; i++) c500();
        for (int i = 0; i < 4; i++) c100();
        c500(); c100(); c100();
        step(0, 0, 0, 0, 1, 1);
        quiet(12);

        // Timeout, then timeout restarted by a later coin
        c100(); quiet(12);
        c100(); quiet(5); c100(); quiet(12);

        // Priority: cancel beats select beats coin
        c500();
        step(1, 0, 1, 0, 1, 1);
        quiet(6);

        // Both coins together in IDLE
        step(1, 1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1, 1);
        quiet(4);

        // Insufficient credit denied, select/coin while busy
        c100(); pick(3); pick(1);
        c500(); pick(1);
        step(1, 0, 1, 0, 0, 1);
        quiet(6);

        // Reset during CHANGE, then select in IDLE
        c500(); c500(); c100(); c100(); pick(0);
        quiet(2);
        step(0, 0, 0, 0, 0, 0);
        quiet(3);
        pick(1);
        quiet(2);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(7) == 0,
                 $urandom_range(15) == 0,
                 $urandom_range(11) == 0,
                 int'($urandom_range(3)),
                 $urandom_range(39) == 0,
                 $urandom_range(599) != 0);
        end
        quiet(3);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge i_clk);
        #2;
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vend_ctrl.md
# vend_ctrl

Vending-machine sequencing controller. It accepts 100/500-won coin pulses, tracks credit, and vends a selected product when credit covers its price. It returns change as a stream of coin pulses and refunds on cancel or inactivity timeout. It owns its own seconds prescaler for the timeout and sits between the debounced button/coin front end and the actuator/display logic.

## Interface
- CLK_HZ, 100, i_clk frequency; one timeout second = CLK_HZ cycles (≥2)
- TIMEOUT_S, 10, idle seconds in CREDIT before automatic refund (≥1)
- PRICE0..PRICE3, 3/5/7/12, item prices in 100-won units (1..MAX_CREDIT)
- MAX_CREDIT, 30, credit ceiling in 100-won units (≤63)
- i_clk  in  1  system clock, all logic on posedge
- reset  in  1  synchronous, active-low reset
- coin_100  in  1  one-cycle pulse, 100-won coin inserted
- coin_500  in  1  one-cycle pulse, 500-won coin inserted
- sel_valid  in  1  one-cycle pulse, product selected
- sel  in  2  product index, valid with sel_valid
- cancel  in  1  one-cycle pulse, refund request
- credit  out  6  current credit, 100-won units
- vend  out  1  one-cycle pulse, dispense item
- vend_item  out  2  item index, valid with vend
- deny  out  1  one-cycle pulse, select refused (insufficient credit or wrong state)
- coin_reject  out  1  one-cycle pulse, inserted coin returned unaccepted
- change_100 / change_500  out  1 each  one-cycle pulse per returned coin
- busy  out  1  high in VEND and CHANGE

## Operation
- States: IDLE, CREDIT, VEND, CHANGE. Reset: IDLE; credit=0; all pulse outputs 0; busy=0; prescaler and seconds counter 0.
- Coin value: coin_100=1, coin_500=5. Both asserted in the same cycle: coin_500 is evaluated, coin_100 is rejected.
- IDLE:
  - Accepted coin adds its value and moves to CREDIT.
  - sel_valid produces deny.
  - cancel is ignored.
- CREDIT priority is cancel > select > coin. A lower-priority event in the same cycle is dropped; a dropped coin pulses coin_reject.
  - cancel: go to CHANGE.
  - sel_valid with credit ≥ PRICE[sel]: go to VEND, latch sel.
  - sel_valid with credit < PRICE[sel]: deny; stay in CREDIT.
  - Coin: accepted if credit+value ≤ MAX_CREDIT, otherwise coin_reject with credit unchanged.
  - Timeout: go to CHANGE.
- VEND (exactly 1 cycle):
  - vend=1, vend_item=latched sel.
  - credit ← credit − PRICE, with no underflow by construction.
  - Next state is CHANGE if the new credit > 0, else IDLE.
- CHANGE: one coin per cycle.
  - If credit ≥ 5: change_500 and credit −= 5.
  - Else if credit ≥ 1: change_100 and credit −= 1.
  - When credit = 0 at the start of a cycle, go to IDLE with no pulse.
- Any coin in VEND/CHANGE pulses coin_reject. Any sel_valid in VEND/CHANGE pulses deny. cancel in VEND/CHANGE is ignored.
- Timeout counter:
  - Prescaler counts 0..CLK_HZ−1; the seconds counter increments on prescaler wrap.
  - Both counters clear on entry to CREDIT, on each accepted coin, and on each denied select.
  - Timeout fires when seconds = TIMEOUT_S, i.e. exactly TIMEOUT_S·CLK_HZ cycles after the last clear with no activity.
  - Both counters are held at 0 outside CREDIT.
- Reset mid-operation (any state): immediate return to reset values. Credit is discarded with no refund pulses.

## Timing
- Inputs are sampled at posedge N. All outputs are registered and take effect from posedge N (visible in cycle N+1).
- Coin in IDLE at edge N: credit and state=CREDIT from edge N.
- Accepted select at edge N:
  - vend pulse high in cycle after edge N+1.
  - First change pulse after edge N+2.
  - A refund of k coins ends with busy=0 after edge N+2+k.
- deny and coin_reject are 1-cycle pulses in the cycle after the offending input.
- credit output always equals the internal credit register, with no extra latency.

## Test plan
- Reset, then coin_500, coin_100, coin_100 (credit 7), then sel=2 (price 7) → vend pulse with vend_item=2; credit 0; back to IDLE; no change pulses.
- Credit 11, sel=0 (price 3) → vend; credit 8; then change_500 followed by 3×change_100 on consecutive cycles; then IDLE with busy=0.
- Credit 29, coin_500 → coin_reject with credit 29. Then coin_100 → credit 30. Then coin_100 → coin_reject.
- CLK_HZ=4, TIMEOUT_S=2: coin_100, then no activity → CHANGE entered exactly 8 cycles after the coin edge; one change_100. Repeat with a coin at cycle 6 → timeout moves 8 cycles past that coin.
- Credit 5 with simultaneous cancel+sel_valid+coin_100 → CHANGE entered; no vend; coin_reject; one change_500. Both coins in the same IDLE cycle → credit 5 plus coin_reject.
- Credit 12, selection accepted, then reset asserted during CHANGE after the first change pulse → next cycle is IDLE with credit=0 and no further pulses. sel_valid in IDLE → deny.
